// File: rtl/tf_buffer_pkg.sv
// tf_buffer_pkg: shared defaults, empty-slot constant and index-field extraction for the track-fit buffer
package tf_buffer_pkg;
   localparam int ADDR_W_DEF = 5;
   localparam int TMUX_DEF = 6;
   localparam int IDX_LSB_DEF = 59;
   localparam int IDX_W_DEF = 54;
   localparam int MAX_W = 512;
   localparam logic [MAX_W-1:0] IDX_EMPTY = '1;
   function automatic logic [MAX_W-1:0] get_index(input logic [MAX_W-1:0] word, input int lsb, input int w);
      return (word >> lsb) & ~(IDX_EMPTY << w);
   endfunction
endpackage

// File: rtl/pipe_delay.sv
// pipe_delay: D-stage delay line; rst zeroes the stored stages while the input still enters stage 0
module pipe_delay #(
   parameter int W = 1,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);
   logic [W-1:0] st [D];
   always_ff @(posedge clk) begin
      st[0] <= din;
      for (int i = 1; i < D; i++) st[i] <= rst ? '0 : st[i-1];
   end
   assign dout = st[D-1];
endmodule

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, registered read address and registered, resettable read data
module sdp_ram #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [2**AW];
   logic [AW-1:0] raddr_r;
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      raddr_r <= raddr;
      rdata <= rst ? '0 : mem[raddr_r];
   end
endmodule

// File: rtl/track_fit_buffer.sv
// track_fit_buffer: paged capture of fitted tracks with per-BX counts, overflow flag and
// previous-BX stub-index export
module track_fit_buffer
   import tf_buffer_pkg::*;
#(
   parameter int DATA_W = 126,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int PAGE_W = 1,
   parameter int BX_W = 3,
   parameter int IDX_LSB = IDX_LSB_DEF,
   parameter int IDX_W = IDX_W_DEF,
   parameter int TMUX = TMUX_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             start,
   output logic [1:0]             done,
   input  logic [DATA_W-1:0]      data_in,
   input  logic                   wr_valid,
   input  logic [BX_W+ADDR_W-1:0] read_add,
   output logic [ADDR_W:0]        number_out,
   output logic [DATA_W-1:0]      data_out,
   output logic [TMUX*IDX_W-1:0]  index_out,
   output logic                   overflow
);
   localparam int PAGES = 2**PAGE_W;
   localparam int CNT_W = ADDR_W + 1;
   logic clr, valid_r, we;
   logic [DATA_W-1:0] data_r;
   logic [BX_W-1:0] bx;
   logic [ADDR_W:0] wr_cnt, cnt_nxt;
   logic [PAGE_W-1:0] page, prev_page, next_page;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] shadow [PAGES][TMUX];
   always_comb begin
      clr = !reset || start[1];
      page = bx[PAGE_W-1:0];
      prev_page = page - PAGE_W'(1);
      next_page = page + PAGE_W'(1);
      we = valid_r && !wr_cnt[ADDR_W] && !clr;
      cnt_nxt = wr_cnt + CNT_W'(we);
      idx = IDX_W'(get_index(MAX_W'(data_r), IDX_LSB, IDX_W));
   end
   // a registered word arriving with the start pulse still belongs to the closing BX
   always_ff @(posedge clk) begin
      data_r <= data_in;
      if (clr) begin
         bx <= '1;
         wr_cnt <= '0;
         overflow <= 1'b0;
         valid_r <= 1'b0;
         index_out <= '1;
         for (int p = 0; p < PAGES; p++)
            for (int i = 0; i < TMUX; i++) shadow[p][i] <= IDX_W'(IDX_EMPTY);
      end else begin
         valid_r <= wr_valid;
         for (int i = 0; i < TMUX; i++) index_out[i*IDX_W +: IDX_W] <= shadow[prev_page][i];
         for (int i = 0; i < TMUX; i++) if (we && int'(wr_cnt) == i) shadow[page][i] <= idx;
         if (start[0]) begin
            bx <= bx + BX_W'(1);
            wr_cnt <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < TMUX; i++) shadow[next_page][i] <= IDX_W'(IDX_EMPTY);
         end else begin
            wr_cnt <= cnt_nxt;
            if (valid_r && wr_cnt[ADDR_W]) overflow <= 1'b1;
         end
      end
   end
   sdp_ram #(.DW(DATA_W), .AW(PAGE_W+ADDR_W)) u_trk (
      .clk, .rst(clr), .we, .waddr({page, wr_cnt[ADDR_W-1:0]}), .wdata(data_r),
      .raddr(read_add[PAGE_W+ADDR_W-1:0]), .rdata(data_out)
   );
   // count entry for the running BX is refreshed every cycle so it is final when the BX closes
   sdp_ram #(.DW(CNT_W), .AW(BX_W)) u_cnt (
      .clk, .rst(clr), .we(!clr), .waddr(bx), .wdata(cnt_nxt),
      .raddr(read_add[BX_W+ADDR_W-1 -: BX_W]), .rdata(number_out)
   );
   pipe_delay #(.W(2), .D(TMUX)) u_done (.clk, .rst(clr), .din(start), .dout(done));
endmodule

// File: tb/tb_track_fit_buffer.sv
// tb_track_fit_buffer: directed checks of a two-page and a four-page buffer against a
// transaction-level model plus hand-computed expectations
module tb_track_fit_buffer;
   logic clk = 1'b0, reset = 1'b0, wr_valid = 1'b0;
   logic [1:0] start = 2'b00;
   logic [125:0] data_in = '0;
   logic [7:0] read_add = '0;
   logic [1:0] done_o [2];
   logic ovf_o [2];
   logic [323:0] idx_o [2];
   logic [5:0] num_o [2];
   logic [125:0] dat_o [2];
   int n_vec = 0, n_bad = 0;

   always #5 clk = ~clk;

   track_fit_buffer u0 (
      .clk(clk), .reset(reset), .start(start), .done(done_o[0]), .data_in(data_in),
      .wr_valid(wr_valid), .read_add(read_add), .number_out(num_o[0]), .data_out(dat_o[0]),
      .index_out(idx_o[0]), .overflow(ovf_o[0])
   );
   track_fit_buffer #(.PAGE_W(2)) u1 (
      .clk(clk), .reset(reset), .start(start), .done(done_o[1]), .data_in(data_in),
      .wr_valid(wr_valid), .read_add(read_add), .number_out(num_o[1]), .data_out(dat_o[1]),
      .index_out(idx_o[1]), .overflow(ovf_o[1])
   );

   function automatic logic [125:0] mkw(input int b, input int k);
      return {30'(b*977 + k), 32'(k*40503 + b + 1), 32'(32'hC0DE0000 + b*256 + k), 32'(~(b*7 + k))};
   endfunction
   function automatic logic [53:0] fidx(input logic [125:0] w);
      return w[59 +: 54];
   endfunction

   task automatic chk(input string nm, input int d, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s u%0d: got %h want %h", nm, d, act, exp);
      end
   endtask

   // model: words accepted per page/slot, final counts per BX, index entries per page
   bit m_on = 1'b0;
   int m_bx [2], m_cnt [2];
   bit m_ovf [2], pv [2];
   logic [125:0] pd [2];
   logic [125:0] mem [2][128];
   bit mv [2][128];
   int ctab [2][8];
   bit cv [2][8];
   logic [53:0] sh [2][4][6];
   logic [323:0] e_idx [2];
   logic [125:0] e_data [2];
   bit e_data_ok [2], e_num_ok [2];
   int e_num [2];
   logic [1:0] dp [2][6];
   logic [7:0] ra_r = '0;

   initial for (int d = 0; d < 2; d++) for (int i = 0; i < 6; i++) dp[d][i] = 2'b00;

   task automatic mstep(input int d);
      int np, a, b, pg, prev;
      bit clr, acc;
      np = d ? 4 : 2;
      clr = !reset || start[1];
      a = int'(ra_r) % (np*32);
      b = int'(ra_r) >> 5;
      e_data[d] = clr ? '0 : mem[d][a];
      e_data_ok[d] = clr || mv[d][a];
      e_num[d] = clr ? 0 : ctab[d][b];
      e_num_ok[d] = clr || cv[d][b];
      for (int i = 5; i > 0; i--) dp[d][i] = clr ? 2'b00 : dp[d][i-1];
      dp[d][0] = start;
      if (clr) begin
         m_on = 1'b1;
         m_bx[d] = 7;
         m_cnt[d] = 0;
         m_ovf[d] = 1'b0;
         pv[d] = 1'b0;
         e_idx[d] = '1;
         for (int p = 0; p < 4; p++) for (int i = 0; i < 6; i++) sh[d][p][i] = '1;
      end else begin
         pg = m_bx[d] % np;
         prev = (pg + np - 1) % np;
         for (int i = 0; i < 6; i++) e_idx[d][i*54 +: 54] = sh[d][prev][i];
         acc = pv[d] && m_cnt[d] < 32;
         if (acc) begin
            mem[d][pg*32 + m_cnt[d]] = pd[d];
            mv[d][pg*32 + m_cnt[d]] = 1'b1;
            if (m_cnt[d] < 6) sh[d][pg][m_cnt[d]] = fidx(pd[d]);
         end
         ctab[d][m_bx[d]] = m_cnt[d] + int'(acc);
         cv[d][m_bx[d]] = 1'b1;
         if (start[0]) begin
            for (int i = 0; i < 6; i++) sh[d][(pg+1) % np][i] = '1;
            m_bx[d] = (m_bx[d] + 1) % 8;
            m_cnt[d] = 0;
            m_ovf[d] = 1'b0;
         end else begin
            m_cnt[d] += int'(acc);
            if (pv[d] && !acc) m_ovf[d] = 1'b1;
         end
         pv[d] = wr_valid;
      end
      pd[d] = data_in;
   endtask

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) mstep(d);
      ra_r = read_add;
   end

   always @(negedge clk) if (m_on) for (int d = 0; d < 2; d++) begin
      chk("done", d, 512'(done_o[d]), 512'(dp[d][5]));
      chk("overflow", d, 512'(ovf_o[d]), 512'(m_ovf[d]));
      chk("index_out", d, 512'(idx_o[d]), 512'(e_idx[d]));
      if (e_num_ok[d]) chk("number_out", d, 512'(num_o[d]), 512'(e_num[d]));
      if (e_data_ok[d]) chk("data_out", d, 512'(dat_o[d]), 512'(e_data[d]));
   end

   task automatic tick(input logic [1:0] s, input logic v, input logic [125:0] w);
      start = s;
      wr_valid = v;
      data_in = w;
      @(negedge clk);
   endtask
   task automatic idle(input int n);
      repeat (n) tick(2'b00, 1'b0, '0);
   endtask
   task automatic rd(input int b, input int s);
      read_add = {3'(b), 5'(s)};
      idle(2);
   endtask

   initial begin
      logic [323:0] ei;
      idle(2);
      reset = 1'b1;
      // basic capture in BX 0
      tick(2'b01, 1'b0, '0);
      for (int k = 0; k < 3; k++) tick(2'b00, 1'b1, mkw(0, k));
      idle(2);
      tick(2'b01, 1'b0, '0);
      idle(1);
      ei = '1;
      for (int k = 0; k < 3; k++) ei[k*54 +: 54] = fidx(mkw(0, k));
      rd(0, 0);
      for (int d = 0; d < 2; d++) begin
         chk("count_bx0", d, 512'(num_o[d]), 512'(3));
         chk("slot0_A", d, 512'(dat_o[d]), 512'(mkw(0, 0)));
         chk("index_abc", d, 512'(idx_o[d]), 512'(ei));
      end
      rd(0, 1);
      for (int d = 0; d < 2; d++) chk("slot1_B", d, 512'(dat_o[d]), 512'(mkw(0, 1)));
      rd(0, 2);
      for (int d = 0; d < 2; d++) chk("slot2_C", d, 512'(dat_o[d]), 512'(mkw(0, 2)));
      // overflow in BX 1
      for (int k = 0; k < 34; k++) tick(2'b00, 1'b1, mkw(1, k));
      idle(2);
      for (int d = 0; d < 2; d++) chk("ovf_set", d, 512'(ovf_o[d]), 512'(1));
      tick(2'b01, 1'b0, '0);
      for (int d = 0; d < 2; d++) chk("ovf_clr", d, 512'(ovf_o[d]), 512'(0));
      rd(1, 0);
      for (int d = 0; d < 2; d++) chk("count_sat", d, 512'(num_o[d]), 512'(32));
      rd(1, 31);
      for (int d = 0; d < 2; d++) chk("slot31", d, 512'(dat_o[d]), 512'(mkw(1, 31)));
      // hard reset in the middle of BX 2
      tick(2'b00, 1'b1, mkw(2, 0));
      tick(2'b00, 1'b1, mkw(2, 1));
      reset = 1'b0;
      tick(2'b00, 1'b1, mkw(2, 2));
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_index", d, 512'(idx_o[d]), {512{1'b0}} | {188'b0, {324{1'b1}}});
         chk("rst_number", d, 512'(num_o[d]), 512'(0));
         chk("rst_done", d, 512'(done_o[d]), 512'(0));
      end
      tick(2'b01, 1'b0, '0);
      idle(2);
      tick(2'b01, 1'b0, '0);
      idle(1);
      rd(0, 0);
      for (int d = 0; d < 2; d++) chk("rst_bx0_cnt", d, 512'(num_o[d]), 512'(0));
      // pipelined reset
      tick(2'b00, 1'b1, mkw(5, 0));
      tick(2'b10, 1'b0, '0);
      for (int d = 0; d < 2; d++) begin
         chk("prst_index", d, 512'(idx_o[d]), {188'b0, {324{1'b1}}});
         chk("prst_number", d, 512'(num_o[d]), 512'(0));
      end
      idle(5);
      for (int d = 0; d < 2; d++) chk("prst_done", d, 512'(done_o[d]), 512'(2'b10));
      idle(1);
      // page wrap, each BX opened with a word in the start cycle
      for (int b = 0; b < 5; b++) begin
         tick(2'b01, 1'b1, mkw(10 + b, 0));
         for (int k = 1; k <= b; k++) tick(2'b00, 1'b1, mkw(10 + b, k));
         idle(2);
      end
      tick(2'b01, 1'b0, '0);
      idle(1);
      for (int b = 0; b < 5; b++) begin
         rd(b, 0);
         for (int d = 0; d < 2; d++) chk("wrap_count", d, 512'(num_o[d]), 512'(b + 1));
      end
      rd(0, 0);
      for (int d = 0; d < 2; d++) chk("wrap_slot0", d, 512'(dat_o[d]), 512'(mkw(14, 0)));
      rd(0, 1);
      for (int d = 0; d < 2; d++) chk("wrap_slot1", d, 512'(dat_o[d]), 512'(mkw(14, 1)));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
